audio_decim_fifo: RTL

AUDIO_DECIM_FIFO -- requirements
Module: audio_decim_fifo

---
 rtl/audio_decim_fifo.sv | 105 ++++++++++
 1 files changed

// File: rtl/audio_decim_fifo.sv
// Block-average decimator (DECIM = 2^LOG2_DECIM) feeding a 2^ADDR-deep first-word-fall-through FIFO.
// Optional build macro: DECIM_ROUND_EN selects round-half-up instead of truncation.
module audio_decim_fifo #(
    parameter int WIDTH      = 16,
    parameter int LOG2_DECIM = 2,
    parameter int ADDR       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] data_i,
    input  logic                    valid_i,
    output logic signed [WIDTH-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [ADDR:0]           level_o,
    output logic                    full_o,
    output logic                    drop_o
);

    localparam int AW    = WIDTH + LOG2_DECIM;
    localparam int DEPTH = 1 << ADDR;
    localparam logic [ADDR:0] DEPTH_L = (ADDR+1)'(DEPTH);

    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    sum;
    logic signed [AW:0]      sum_adj;
    logic [LOG2_DECIM-1:0]   cnt;
    logic signed [WIDTH-1:0] res;
    logic                    res_vld;

    assign sum = acc + {{LOG2_DECIM{data_i[WIDTH-1]}}, data_i};

`ifdef DECIM_ROUND_EN
    localparam logic [AW:0] HALF = (AW+1)'(1) << (LOG2_DECIM - 1);
    assign sum_adj = {sum[AW-1], sum} + $signed(HALF);
`else
    assign sum_adj = {sum[AW-1], sum};
`endif

    // Accumulate DECIM valid samples, then emit their arithmetic-shifted sum for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            if (valid_i) begin
                if (&cnt) begin
                    res     <= WIDTH'(sum_adj >>> LOG2_DECIM);
                    res_vld <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Handshake: a word transfers on any rising edge where valid_o && ready_i; data_o is
    // stable while valid_o is high and ready_i is low. Upstream has no backpressure, so
    // a result arriving at a full FIFO with no simultaneous pop is dropped.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR-1:0]  wr_ptr;
    logic [ADDR-1:0]  rd_ptr;
    logic [ADDR:0]    count;
    logic             push;
    logic             pop;
    logic             push_ok;

    assign push    = res_vld;
    assign pop     = valid_o && ready_i;
    assign push_ok = push && ((count != DEPTH_L) || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop_o <= 1'b0;
        end else begin
            drop_o <= push && !push_ok;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign valid_o = (count != '0);
    assign full_o  = (count == DEPTH_L);
    assign level_o = count;
    // Gated so uncleared memory never leaks X onto the output while empty.
    assign data_o  = valid_o ? $signed(mem[rd_ptr]) : '0;

endmodule
